// File: rtl/mult_dispatcher.sv
// Request FIFO plus issue/collect FSM in front of the 4x16 sequential multiplier.
// Each popped request gets exactly one st pulse and exactly one in-order response, or an error response on timeout.
//   state | meaning
//   IDLE  | waiting for a queued request while m_done is low
//   START | m_st high for one cycle, timer cleared
//   BUSY  | waiting for m_done, timer counting toward TIMEOUT
//   RESP  | response presented until rsp_ready
module mult_dispatcher #(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4,
  parameter int TIMEOUT    = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [3:0]                    req_mcand,
  input  logic [15:0]                   req_mult,
  input  logic [TAG_W-1:0]              req_tag,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [19:0]                   rsp_product,
  output logic [TAG_W-1:0]              rsp_tag,
  output logic                          rsp_err,
  output logic                          m_st,
  output logic [3:0]                    m_mcand,
  output logic [15:0]                   m_mult,
  input  logic [19:0]                   m_product,
  input  logic                          m_done,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT) + 1;
  localparam int ENT_W = 4 + 16 + TAG_W;

  typedef enum logic [1:0] {IDLE, START, BUSY, RESP} state_t;

  logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  state_t           state;
  logic [TMR_W-1:0] timer;
  logic [TAG_W-1:0] op_tag;
  logic             full;
  logic             push;
  logic             pop;

  // No push-through when full: a same-cycle pop does not free a slot for this cycle's push.
  assign full       = (level == LVL_W'(FIFO_DEPTH));
  assign req_ready  = !full;
  assign push       = req_valid && req_ready;
  assign pop        = (state == IDLE) && (level != '0) && !m_done;
  assign fifo_level = level;
  assign busy       = (state != IDLE) || (level != '0);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {req_mcand, req_mult, req_tag};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      timer       <= '0;
      m_st        <= 1'b0;
      m_mcand     <= '0;
      m_mult      <= '0;
      op_tag      <= '0;
      rsp_valid   <= 1'b0;
      rsp_product <= '0;
      rsp_tag     <= '0;
      rsp_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            {m_mcand, m_mult, op_tag} <= fifo_mem[rd_ptr];
            m_st  <= 1'b1;
            state <= START;
          end
        end
        START: begin
          m_st  <= 1'b0;
          timer <= '0;
          state <= BUSY;
        end
        BUSY: begin
          timer <= timer + TMR_W'(1);
          // done takes priority over a timeout landing on the same cycle
          if (m_done) begin
            rsp_product <= m_product;
            rsp_err     <= 1'b0;
            rsp_tag     <= op_tag;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end else if (timer == TMR_W'(TIMEOUT - 1)) begin
            rsp_product <= '0;
            rsp_err     <= 1'b1;
            rsp_tag     <= op_tag;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_dispatcher.sv
// Bench for mult_dispatcher: behavioural multiplier model, in-order scoreboard, directed corner cases, random traffic.
`timescale 1ns/1ps
module tb_mult_dispatcher;
  localparam int FIFO_DEPTH = 4;
  localparam int TAG_W      = 4;
  localparam int TIMEOUT    = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req_valid, req_ready;
  logic [3:0]        req_mcand;
  logic [15:0]       req_mult;
  logic [TAG_W-1:0]  req_tag;
  logic              rsp_valid, rsp_ready;
  logic [19:0]       rsp_product;
  logic [TAG_W-1:0]  rsp_tag;
  logic              rsp_err;
  logic              m_st;
  logic [3:0]        m_mcand;
  logic [15:0]       m_mult;
  logic [19:0]       m_product;
  logic              m_done;
  logic              busy;
  logic [2:0]        fifo_level;

  mult_dispatcher #(.FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_mcand(req_mcand), .req_mult(req_mult), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_product(rsp_product), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .m_st(m_st), .m_mcand(m_mcand), .m_mult(m_mult), .m_product(m_product), .m_done(m_done),
    .busy(busy), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // Sequential multiplier model: latches operands on st, pulses done mul_lat cycles later.
  int          mul_lat    = 3;
  logic        mul_hang   = 1'b0;
  logic        force_done = 1'b0;
  int          mcnt;
  logic [3:0]  pa;
  logic [15:0] pb;
  logic        mdone_r;
  logic [19:0] mprod_r;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcnt <= 0; pa <= '0; pb <= '0; mdone_r <= 1'b0; mprod_r <= '0;
    end else begin
      mdone_r <= 1'b0;
      if (m_st) begin
        mcnt <= mul_lat; pa <= m_mcand; pb <= m_mult;
      end else if (mcnt > 0) begin
        mcnt <= mcnt - 1;
        if (mcnt == 1 && !mul_hang) begin
          mdone_r <= 1'b1;
          mprod_r <= 20'(pa) * 20'(pb);
        end
      end
    end
  end
  assign m_done    = mdone_r | force_done;
  assign m_product = mprod_r;

  typedef struct { logic [TAG_W-1:0] tag; logic [19:0] prod; logic err; } rsp_t;
  typedef struct { logic [3:0] a; logic [15:0] b; logic [TAG_W-1:0] t; logic [19:0] p; } vec_t;

  rsp_t exp_q[$];
  rsp_t log_q[$];
  rsp_t mon_e, mon_g;
  int   n_vec = 0, n_bad = 0;
  int   st_cnt = 0, acc_cnt = 0, rsp_cnt = 0;
  logic prev_st = 1'b0, hold = 1'b0, hold_e;
  logic [19:0] hold_p;
  logic [TAG_W-1:0] hold_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every accepted request expects exactly one response, in acceptance order.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      prev_st = 1'b0; hold = 1'b0;
    end else begin
      if (req_valid && req_ready) begin
        mon_e.tag  = req_tag;
        mon_e.err  = mul_hang;
        mon_e.prod = mul_hang ? 20'd0 : 20'(req_mcand) * 20'(req_mult);
        exp_q.push_back(mon_e);
        acc_cnt++;
      end
      if (m_st) begin
        st_cnt++;
        chk("st_single_cycle", {31'd0, prev_st}, 0);
      end
      prev_st = m_st;
      if (hold && rsp_valid) begin
        chk("hold_product", rsp_product, hold_p);
        chk("hold_tag", rsp_tag, hold_t);
        chk("hold_err", rsp_err, hold_e);
      end else if (hold) begin
        chk("hold_valid", rsp_valid, 1);
      end
      hold = rsp_valid && !rsp_ready;
      hold_p = rsp_product; hold_t = rsp_tag; hold_e = rsp_err;
      if (rsp_valid && rsp_ready) begin
        rsp_cnt++;
        mon_g.tag = rsp_tag; mon_g.prod = rsp_product; mon_g.err = rsp_err;
        log_q.push_back(mon_g);
        if (exp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL rsp_unexpected: got tag %0d product %0d with nothing outstanding", rsp_tag, rsp_product);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_tag", rsp_tag, mon_e.tag);
          chk("sb_product", rsp_product, mon_e.prod);
          chk("sb_err", rsp_err, mon_e.err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [3:0] a, input logic [15:0] b, input logic [TAG_W-1:0] t);
    int n = 0;
    req_valid = 1'b1; req_mcand = a; req_mult = b; req_tag = t;
    while (!req_ready && n < 500) begin tick(); n++; end
    if (n >= 500) begin
      n_vec++; n_bad++;
      $display("FAIL push_timeout: req_ready stayed low, got 0 required 1 for tag %0d", t);
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < 200) begin tick(); cyc++; end
    if (!rsp_valid) begin
      n_vec++; n_bad++;
      $display("FAIL rsp_timeout: rsp_valid got 0 required 1 within %0d cycles", cyc);
    end
  endtask

  task automatic drain();
    int n = 0;
    rsp_ready = 1'b1;
    while ((busy || rsp_valid || exp_q.size() != 0) && n < 3000) begin tick(); n++; end
    if (n >= 3000) begin
      n_vec++; n_bad++;
      $display("FAIL drain_timeout: %0d responses still outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  vec_t burst[6];
  int   c, s0, a0, r0;

  initial begin
    burst[0] = '{4'd15, 16'd0,     4'd0, 20'd0};
    burst[1] = '{4'd15, 16'd65535, 4'd1, 20'd983025};
    burst[2] = '{4'd7,  16'd9,     4'd2, 20'd63};
    burst[3] = '{4'd1,  16'd1,     4'd3, 20'd1};
    burst[4] = '{4'd2,  16'd3,     4'd4, 20'd6};
    burst[5] = '{4'd4,  16'd4,     4'd5, 20'd16};

    req_valid = 1'b0; req_mcand = '0; req_mult = '0; req_tag = '0; rsp_ready = 1'b0;
    #12;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_m_st", m_st, 0);
    chk("rst_m_ops", {m_mcand, m_mult}, 0);
    chk("rst_rsp_data", {rsp_product, rsp_tag, rsp_err}, 0);
    rst = 1'b1;
    tick();

    // single op with start-latency check
    rsp_ready = 1'b1; mul_lat = 4;
    push(4'd3, 16'd1000, 4'd5);
    chk("t1_level", fifo_level, 1);
    chk("t1_st_before", m_st, 0);
    tick(); chk("t1_st_pulse", m_st, 1);
    chk("t1_m_mcand", m_mcand, 3);
    chk("t1_m_mult", m_mult, 1000);
    tick(); chk("t1_st_after", m_st, 0);
    wait_rsp(c);
    chk("t1_product", rsp_product, 3000);
    chk("t1_tag", rsp_tag, 5);
    chk("t1_err", rsp_err, 0);
    tick();
    chk("t1_busy_clear", busy, 0);
    chk("t1_valid_clear", rsp_valid, 0);

    // burst until full, then drain in order
    rsp_ready = 1'b0; mul_lat = 3; log_q.delete();
    for (int i = 0; i < 5; i++) push(burst[i].a, burst[i].b, burst[i].t);
    chk("t2_full_ready", req_ready, 0);
    chk("t2_full_level", fifo_level, 4);
    rsp_ready = 1'b1;
    push(burst[5].a, burst[5].b, burst[5].t);
    drain();
    chk("t2_rsp_count", log_q.size(), 6);
    for (int i = 0; i < 6 && i < log_q.size(); i++) begin
      chk("t2_tag", log_q[i].tag, burst[i].t);
      chk("t2_product", log_q[i].prod, burst[i].p);
      chk("t2_err", log_q[i].err, 0);
    end
    tick();

    // backpressure holds response and blocks the next start
    rsp_ready = 1'b0; mul_lat = 5;
    push(4'd15, 16'd65535, 4'd7);
    push(4'd2, 16'd3, 4'd8);
    wait_rsp(c);
    s0 = st_cnt;
    repeat (20) tick();
    chk("t3_valid", rsp_valid, 1);
    chk("t3_product", rsp_product, 983025);
    chk("t3_tag", rsp_tag, 7);
    chk("t3_no_st", st_cnt, s0);
    rsp_ready = 1'b1;
    tick();
    chk("t3_st_after_hs", m_st, 0);
    tick();
    chk("t3_next_st", m_st, 1);
    drain();
    tick();

    // timeout with a hung multiplier, then a healthy op
    mul_hang = 1'b1; rsp_ready = 1'b1;
    push(4'd5, 16'd5, 4'd9);
    tick(); chk("t4_st", m_st, 1);
    wait_rsp(c);
    chk("t4_timeout_cycles", c, TIMEOUT + 1);
    chk("t4_err", rsp_err, 1);
    chk("t4_product", rsp_product, 0);
    chk("t4_tag", rsp_tag, 9);
    mul_hang = 1'b0;
    tick();
    push(4'd2, 16'd3, 4'd10);
    wait_rsp(c);
    chk("t4_after_product", rsp_product, 6);
    chk("t4_after_err", rsp_err, 0);
    tick();

    // stuck done blocks start until it falls
    force_done = 1'b1;
    s0 = st_cnt;
    push(4'd4, 16'd5, 4'd11);
    repeat (10) tick();
    chk("t5_no_st", st_cnt, s0);
    chk("t5_level", fifo_level, 1);
    force_done = 1'b0;
    tick();
    chk("t5_st_after_fall", m_st, 1);
    drain();
    tick();

    // async reset mid-BUSY with three queued
    mul_lat = 20; rsp_ready = 1'b1;
    push(4'd1, 16'd2, 4'd1);
    push(4'd3, 16'd4, 4'd2);
    push(4'd5, 16'd6, 4'd3);
    push(4'd7, 16'd8, 4'd4);
    chk("t6_level_before", fifo_level, 3);
    chk("t6_busy_before", busy, 1);
    #2; rst = 1'b0; #1;
    chk("t6_level", fifo_level, 0);
    chk("t6_busy", busy, 0);
    chk("t6_rsp_valid", rsp_valid, 0);
    chk("t6_req_ready", req_ready, 1);
    chk("t6_m_ops", {m_st, m_mcand, m_mult}, 0);
    exp_q.delete();
    @(posedge clk); @(posedge clk); #3; rst = 1'b1;
    tick();
    r0 = rsp_cnt; s0 = st_cnt;
    repeat (30) tick();
    chk("t6_no_rsp", rsp_cnt, r0);
    chk("t6_no_st", st_cnt, s0);
    mul_lat = 3;
    push(4'd3, 16'd1000, 4'd12);
    wait_rsp(c);
    chk("t6_product", rsp_product, 3000);
    chk("t6_tag", rsp_tag, 12);
    tick();

    // random traffic against the scoreboard
    s0 = st_cnt; a0 = acc_cnt;
    for (int i = 0; i < 400; i++) begin
      req_valid = ($urandom_range(0, 2) != 0);
      req_mcand = 4'($urandom);
      req_mult  = 16'($urandom);
      req_tag   = TAG_W'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      mul_lat   = int'($urandom_range(1, 6));
      tick();
    end
    req_valid = 1'b0;
    drain();
    chk("rand_st_per_accept", st_cnt - s0, acc_cnt - a0);
    chk("rand_idle_level", fifo_level, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mult_dispatcher.md
Name: mult_dispatcher

Overview:
Request-side front end for the 4x16 sequential multiplier. Buffers tagged multiply requests in a small FIFO and issues them one at a time over the multiplier's st/done handshake. Captures each product and returns it in order on a valid/ready response port. Adds a per-operation timeout so a hung multiplier cannot stall the pipeline.

Parameters:
FIFO_DEPTH, 4, request FIFO entries; must be a power of 2, ≥2
TAG_W, 4, width of the opaque request tag, returned unchanged with the result
TIMEOUT, 32, maximum cycles in BUSY waiting for m_done before forcing an error response

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
req_valid  in  1  request offered
req_ready  out  1  FIFO can accept; equals !full
req_mcand  in  4  multiplicand
req_mult  in  16  multiplier
req_tag  in  TAG_W  request tag
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_product  out  20  product (0 on error)
rsp_tag  out  TAG_W  tag of this result
rsp_err  out  1  1 = timed out
m_st  out  1  start pulse to multiplier
m_mcand  out  4  operand to multiplier
m_mult  out  16  operand to multiplier
m_product  in  20  multiplier result
m_done  in  1  multiplier completion
busy  out  1  state != IDLE or FIFO non-empty
fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst=0, async): FIFO flushed, level 0, state IDLE, timer 0; all outputs 0 except req_ready=1.
- FIFO: push on req_valid&&req_ready; req_ready = !full only (no push-through when full, even on a same-cycle pop). Push and pop in the same cycle leave level unchanged. Pointers wrap modulo FIFO_DEPTH. Order is strict FIFO.
- FSM states: IDLE, START, BUSY, RESP.
- IDLE: if level>0 and m_done==0, pop the head into op regs {mcand,mult,tag} and go to START. If m_done==1, wait; never start while done is still asserted.
- START: m_st=1 for exactly this one cycle; clear timer; go to BUSY.
- BUSY: m_st=0; timer increments each cycle.
  - If m_done=1: capture m_product, set err=0, go to RESP.
  - Otherwise, if timer==TIMEOUT-1: set product=0, err=1, go to RESP.
  - If done arrives on the timeout cycle, done wins.
- RESP: rsp_valid=1 with registered product/tag/err. On rsp_ready, go to IDLE.
  - Outputs stay stable while rsp_valid && !rsp_ready.
  - A late m_done arriving in RESP or IDLE after a timeout is ignored; the IDLE done==0 rule prevents a spurious start.
- m_mcand/m_mult are driven from op regs, valid from START until the return to IDLE, and held stable throughout BUSY. They are 0 after reset.
- m_st is a registered output and never glitches. At most one st per popped request.
- Latency: a request accepted on edge E into an empty FIFO with an idle multiplier has m_st high in the cycle after edge E+1. The response is valid the cycle after the edge that samples m_done=1.
- Reset mid-operation (any state): immediate return to reset values. In-flight and queued requests are discarded with no response. The multiplier shares the same reset.
- No arithmetic is done here; product width is fixed at 20 bits (4+16).

Test Plan:
1. Single op: mcand=3, mult=1000, tag=5, rsp_ready=1 -> m_st high exactly 1 cycle; rsp_product=3000, rsp_tag=5, rsp_err=0; busy then returns to 0.
2. Burst/full: rsp_ready=0, push 6 requests back-to-back, tags 0..5 (15*0, 15*65535, 7*9, 1*1, 2*3, 4*4) -> req_ready drops after the 5th accept (1 in op + 4 queued), fifo_level=4. Raise rsp_ready -> responses 0, 983025, 63, 1, 6, 16 with tags 0..5 in order.
3. Backpressure: complete 15*65535 with rsp_ready=0 for 20 cycles -> rsp_valid, product 983025 and tag held stable; no m_st issued; the next queued op starts only after the handshake.
4. Timeout: multiplier model never asserts done -> rsp_err=1, rsp_product=0 exactly TIMEOUT cycles after BUSY entry. A following 2*3 request with a healthy model returns 6, err=0.
5. Stuck done: hold m_done=1 with a request queued -> no m_st while done=1; st issued the cycle after done falls.
6. Async reset mid-BUSY with 3 queued: drop rst between clock edges -> outputs clear immediately, fifo_level=0, no response. After release, 3*1000 returns 3000.
